// File: rtl/connect_four_drop_unit.sv
`default_nettype none
// ============================================================================
//  Module   : connect_four_drop_unit
//  Purpose  : Owns the Connect-Four board and drops one piece per accepted
//             move, one row per step from the top. It writes the landing cell
//             and reports the result with a one-cycle drop_done pulse.
//             Optional falling-piece animation is enabled by the macro
//             DROP_ANIM_EN. Each row is then held ANIM_HOLD cycles.
//  Revision : 1.0  initial release
// ============================================================================
module connect_four_drop_unit #(
  parameter int ROWS      = 6,
  parameter int COLS      = 8,
  parameter int ANIM_HOLD = 4,
  localparam int CW       = $clog2(COLS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [CW-1:0]                    req_col,
  input  logic [1:0]                       req_player,
  output logic                             drop_done,
  output logic                             drop_ok,
  output logic [2:0]                       drop_row,
  output logic [ROWS-1:0][COLS-1:0][1:0]   board,
  output logic                             board_full,
  output logic                             anim_valid,
  output logic [2:0]                       anim_row,
  output logic [CW-1:0]                    anim_col
);

  localparam logic [1:0] c_EMPTY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FALL  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [1:0]    r_player;
  logic [2:0]    r_ptr;

  logic          w_col_ok;
  logic          w_player_ok;
  logic          w_top_empty;
  logic          w_below_empty;
  logic          w_step;

  // A zero hold time would make the fall take no cycles at all.
  if (ANIM_HOLD < 1) begin : g_hold_check
    $error("ANIM_HOLD must be at least 1");
  end

`ifdef DROP_ANIM_EN
  localparam int            HW            = (ANIM_HOLD > 1) ? $clog2(ANIM_HOLD) : 1;
  localparam logic [HW-1:0] c_HOLD_RELOAD = HW'(ANIM_HOLD - 1);
  logic [HW-1:0] r_hold;

  // The fall advances only once the current row has been shown long enough.
  assign w_step = (r_hold == '0);
`else
  assign w_step     = 1'b1;
  assign anim_valid = 1'b0;
  assign anim_row   = '0;
  assign anim_col   = '0;
`endif

  assign req_ready   = (r_state == S_IDLE) && !clear;
  assign w_col_ok    = (int'(r_col) < COLS);
  assign w_player_ok = (r_player == 2'b01) || (r_player == 2'b10);
  assign w_top_empty = w_col_ok && (board[0][r_col] == c_EMPTY);

  // The cell directly under the falling piece, treating the bottom row as a floor.
  always_comb begin
    w_below_empty = 1'b0;
    for (int r = 0; r < ROWS - 1; r++) begin
      if (r_ptr == 3'(r)) begin
        w_below_empty = (board[r+1][r_col] == c_EMPTY);
      end
    end
  end

  // The board counts as full once every column's top cell holds a piece.
  always_comb begin
    board_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (board[0][c] == c_EMPTY) begin
        board_full = 1'b0;
      end
    end
  end

  // Move sequencer and board storage; clear overrides any move in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      board      <= '0;
      r_col      <= '0;
      r_player   <= '0;
      r_ptr      <= '0;
      drop_done  <= 1'b0;
      drop_ok    <= 1'b0;
      drop_row   <= '0;
`ifdef DROP_ANIM_EN
      r_hold     <= '0;
      anim_valid <= 1'b0;
      anim_row   <= '0;
      anim_col   <= '0;
`endif
    end else if (clear) begin
      r_state    <= S_IDLE;
      board      <= '0;
      r_ptr      <= '0;
      drop_done  <= 1'b0;
      drop_ok    <= 1'b0;
      drop_row   <= '0;
`ifdef DROP_ANIM_EN
      r_hold     <= '0;
      anim_valid <= 1'b0;
      anim_row   <= '0;
      anim_col   <= '0;
`endif
    end else begin
      drop_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_col    <= req_col;
            r_player <= req_player;
            r_state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (!w_player_ok || !w_top_empty) begin
            drop_ok   <= 1'b0;
            drop_done <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_ptr   <= '0;
            r_state <= S_FALL;
`ifdef DROP_ANIM_EN
            r_hold     <= c_HOLD_RELOAD;
            anim_valid <= 1'b1;
            anim_row   <= '0;
            anim_col   <= r_col;
`endif
          end
        end

        S_FALL: begin
          if (!w_step) begin
`ifdef DROP_ANIM_EN
            r_hold <= r_hold - 1'b1;
`endif
          end else if (w_below_empty) begin
            r_ptr <= r_ptr + 3'd1;
`ifdef DROP_ANIM_EN
            r_hold   <= c_HOLD_RELOAD;
            anim_row <= r_ptr + 3'd1;
`endif
          end else begin
            r_state <= S_WRITE;
`ifdef DROP_ANIM_EN
            anim_valid <= 1'b0;
            anim_row   <= '0;
            anim_col   <= '0;
`endif
          end
        end

        S_WRITE: begin
          board[r_ptr][r_col] <= r_player;
          drop_ok             <= 1'b1;
          drop_row            <= r_ptr;
          drop_done           <= 1'b1;
          r_state             <= S_RESP;
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_connect_four_drop_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_connect_four_drop_unit
//  Purpose  : Self-checking bench for connect_four_drop_unit. A board-level
//             model predicts every output each cycle. Directed moves and a
//             randomized stream drive the unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_connect_four_drop_unit;
  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int CW   = 3;
  localparam int HOLD = 4;
`ifdef DROP_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic                           clk        = 1'b0;
  logic                           reset_n    = 1'b0;
  logic                           clear      = 1'b0;
  logic                           req_valid  = 1'b0;
  logic [CW-1:0]                  req_col    = '0;
  logic [1:0]                     req_player = '0;
  logic                           req_ready;
  logic                           drop_done;
  logic                           drop_ok;
  logic [2:0]                     drop_row;
  logic [ROWS-1:0][COLS-1:0][1:0] board;
  logic                           board_full;
  logic                           anim_valid;
  logic [2:0]                     anim_row;
  logic [CW-1:0]                  anim_col;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  connect_four_drop_unit #(.ROWS(ROWS), .COLS(COLS), .ANIM_HOLD(HOLD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_col    (req_col),
    .req_player (req_player),
    .drop_done  (drop_done),
    .drop_ok    (drop_ok),
    .drop_row   (drop_row),
    .board      (board),
    .board_full (board_full),
    .anim_valid (anim_valid),
    .anim_row   (anim_row),
    .anim_col   (anim_col)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_board(input string name,
                                    input logic [ROWS*COLS*2-1:0] act,
                                    input logic [ROWS*COLS*2-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int mb [ROWS][COLS];
  bit busy;
  int edge_n;
  int done_at, acc_edge, lat_m;
  bit res_ok;
  int res_row, res_col, res_pl;
  bit exp_done, exp_ok;
  int exp_row;
  bit exp_av;
  int exp_ar, exp_ac;
  bit m_acc;
  int m_r;

  function automatic void model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mb[r][c] = 0;
    busy = 0; exp_done = 0; exp_ok = 0; exp_row = 0;
    exp_av = 0; exp_ar = 0; exp_ac = 0;
  endfunction

  // Lowest empty row of a column, or -1 if the column is full.
  function automatic int land_row(input int col);
    int r;
    r = -1;
    for (int i = 0; i < ROWS; i++)
      if (mb[i][col] == 0) r = i;
    return r;
  endfunction

  initial begin
    edge_n = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        edge_n++;
        if (clear) begin
          model_reset();
        end else begin
          m_acc    = !busy && req_valid;
          exp_done = 0;
          if (busy && edge_n == done_at) begin
            if (res_ok) begin
              mb[res_row][res_col] = res_pl;
              exp_row = res_row;
            end
            exp_ok   = res_ok;
            exp_done = 1;
          end else if (busy && edge_n == done_at + 1) begin
            busy = 0;
          end
          if (m_acc) begin
            res_col  = int'(req_col);
            res_pl   = int'(req_player);
            acc_edge = edge_n;
            busy     = 1;
            m_r      = (res_col < COLS) ? land_row(res_col) : -1;
            if ((res_pl != 1 && res_pl != 2) || m_r < 0) begin
              res_ok = 0;
              lat_m  = 2;
            end else begin
              res_ok  = 1;
              res_row = m_r;
              lat_m   = ANIM ? (m_r * HOLD + HOLD + 3) : (m_r + 4);
            end
            done_at = edge_n + lat_m - 1;
          end
          exp_av = 0; exp_ar = 0; exp_ac = 0;
          if (ANIM && busy && res_ok) begin
            if (edge_n - acc_edge >= 1 && edge_n - acc_edge <= lat_m - 3) begin
              exp_av = 1;
              exp_ar = (edge_n - acc_edge - 1) / HOLD;
              exp_ac = res_col;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [ROWS-1:0][COLS-1:0][1:0] eb;
  bit efull;
  initial begin
    forever begin
      @(negedge clk);
      efull = 1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          eb[r][c] = mb[r][c][1:0];
          if (r == 0 && mb[r][c] == 0) efull = 0;
        end
      chk("req_ready",  req_ready,  (!busy && !clear));
      chk("drop_done",  drop_done,  exp_done);
      chk("drop_ok",    drop_ok,    exp_ok);
      chk("drop_row",   drop_row,   exp_row);
      chk("board_full", board_full, efull);
      chk_board("board", board, eb);
      chk("anim_valid", anim_valid, exp_av);
      chk("anim_row",   anim_row,   exp_ar);
      chk("anim_col",   anim_col,   exp_ac);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_move(input int col, input int pl);
    int n;
    bit rdy;
    @(negedge clk); #1;
    req_col    = col[CW-1:0];
    req_player = pl[1:0];
    req_valid  = 1'b1;
    n = 0; rdy = 0;
    while (!rdy && n < 100) begin
      #1;
      rdy = req_ready;
      @(posedge clk);
      n++;
    end
    chk("accept_in_time", rdy, 1);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (drop_done) break;
    end
    chk("done_in_time", drop_done, 1);
  endtask

  task automatic do_move(input int col, input int pl, output int lat);
    start_move(col, pl);
    wait_done(lat);
  endtask

  task automatic pulse_clear();
    @(negedge clk); #1;
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [ROWS-1:0][COLS-1:0][1:0] lit;
  int lat, cnt, pl, saw, tmp, j;
  int order [COLS];

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_drop_done", drop_done, 0);
    chk("rst_drop_ok", drop_ok, 0);
    lit = '0;
    chk_board("rst_board", board, lit);
    #1 reset_n = 1'b1;

    // Empty board, P1 into column 3
    do_move(3, 1, lat);
    chk("t1_latency", lat, ANIM ? 27 : 9);
    chk("t1_drop_ok", drop_ok, 1);
    chk("t1_drop_row", drop_row, 5);
    lit = '0;
    lit[5][3] = 2'b01;
    chk_board("t1_board", board, lit);

    // Stack column 3 to the top, then overflow it
    for (int i = 0; i < 4; i++) do_move(3, 2 - (i % 2), lat);
    do_move(3, 2, lat);
    chk("t2_latency_top", lat, ANIM ? 7 : 4);
    chk("t2_drop_row", drop_row, 0);
    chk("t2_top_cell", board[0][3], 2);
    do_move(3, 1, lat);
    chk("t2_reject_latency", lat, 2);
    chk("t2_reject_ok", drop_ok, 0);
    chk("t2_reject_row_kept", drop_row, 0);
    chk("t2_top_cell_kept", board[0][3], 2);

    // Illegal players
    pulse_clear();
    do_move(2, 3, lat);
    chk("t3_p11_latency", lat, 2);
    chk("t3_p11_ok", drop_ok, 0);
    do_move(2, 0, lat);
    chk("t3_p00_latency", lat, 2);
    lit = '0;
    chk_board("t3_board", board, lit);

    // Clear during the third fall cycle
    start_move(5, 1);
    repeat (4) @(negedge clk);
    #1 clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    #1;
    chk("t4_ready_after_clear", req_ready, 1);
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (drop_done) saw = 1;
    end
    chk("t4_no_done", saw, 0);
    chk_board("t4_board", board, lit);

    // Fill the whole board in a shuffled column order
    for (int i = 0; i < COLS; i++) order[i] = i;
    for (int i = COLS - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    cnt = 0; pl = 1;
    for (int oi = 0; oi < COLS; oi++)
      for (int r = 0; r < ROWS; r++) begin
        cnt++;
        if (cnt == ROWS * COLS) chk("t5_not_full_before_last", board_full, 0);
        do_move(order[oi], pl, lat);
        pl = 3 - pl;
      end
    chk("t5_full_after_last", board_full, 1);
    do_move(order[0], 1, lat);
    chk("t5_full_col_reject", lat, 2);

    // Asynchronous reset in the middle of a move
    pulse_clear();
    do_move(4, 1, lat);
    chk("t5_pre_reset_ok", drop_ok, 1);
    start_move(4, 2);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_ok", drop_ok, 0);
    chk("t5_rst_row", drop_row, 0);
    chk("t5_rst_done", drop_done, 0);
    chk("t5_rst_anim", anim_valid, 0);
    chk_board("t5_rst_board", board, lit);
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Randomized stream; req_valid may stay high across responses
    repeat (800) begin
      @(negedge clk); #1;
      req_valid  = ($urandom_range(3, 0) != 0);
      req_col    = CW'($urandom_range(COLS - 1, 0));
      req_player = ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0))
                                                : 2'($urandom_range(2, 1));
      clear      = ($urandom_range(79, 0) == 0);
    end
    @(negedge clk); #1;
    req_valid = 1'b0;
    clear     = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
